steamer_core: RTL and testbench

//  Parametrised successor to the 16-bit/4-slot Steamer stack CPU: DW-bit instruction words packed with DW/4 4-bit opcodes,
//  a DEPTH-entry data stack, and a Wishbone-classic master with per-byte strobes. Sits between the boot ROM/RAM bus and the system.

---
 rtl/steamer_pkg.sv | 42 ++++
 rtl/steamer_dstack.sv | 73 +++++++
 rtl/steamer_core.sv | 243 ++++++++++++++++++++++++
 tb/tb_steamer_core.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/steamer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : steamer_pkg
// Brief    : Shared opcodes, sequencer phase encoding and geometry helpers
//            for the Steamer stack CPU.
// Revision : 1.0 - initial release
// ============================================================================
package steamer_pkg;

  // Four-bit slot opcodes. Codes 8, 9 and C..F are unused and decode to
  // either NOP or a trap depending on the build.
  localparam logic [3:0] OPC_NOP = 4'h0;
  localparam logic [3:0] OPC_LIT = 4'h1;
  localparam logic [3:0] OPC_FWM = 4'h2;
  localparam logic [3:0] OPC_SWM = 4'h3;
  localparam logic [3:0] OPC_ADD = 4'h4;
  localparam logic [3:0] OPC_AND = 4'h5;
  localparam logic [3:0] OPC_XOR = 4'h6;
  localparam logic [3:0] OPC_ZGO = 4'h7;
  localparam logic [3:0] OPC_FBM = 4'hA;
  localparam logic [3:0] OPC_SBM = 4'hB;

  // Sequencer phase: instruction fetch, or executing one of the packed slots.
  // The slot number itself lives in a separate counter because the number
  // of slots depends on the word width.
  typedef enum logic [0:0] {
    PH_FETCH = 1'b0,
    PH_SLOT  = 1'b1
  } phase_e;

  // Number of byte-address bits below the word address (log2 of bytes/word).
  function automatic int f_bl(input int dw);
    return (dw == 32) ? 2 : 1;
  endfunction

  // Number of 4-bit opcode slots packed into one instruction word.
  function automatic int f_ns(input int dw);
    return dw / 4;
  endfunction

endpackage
`default_nettype wire

// File: rtl/steamer_dstack.sv
`default_nettype none
// ============================================================================
// Module   : steamer_dstack
// Brief    : DEPTH x DW register data stack. Entry DEPTH-1 is TOS, DEPTH-2
//            is NOS. Push drops entry 0, pops replicate entry 0; both silent.
// Revision : 1.0 - initial release
// ============================================================================
module steamer_dstack
  import steamer_pkg::*;
#(
  parameter int DW    = 16,
  parameter int DEPTH = 3
) (
  input  logic          clk_i,
  input  logic          res_ni,
  input  logic          push,
  input  logic          pop1,
  input  logic          pop2,
  input  logic          wr_tos,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] tos,
  output logic [DW-1:0] nos
);

  logic [DW-1:0] stk_q [DEPTH];
  logic [DW-1:0] stk_d [DEPTH];

  // Next stack image: shift for push/pop, then optionally overwrite TOS
  // (a pop1 followed by a TOS write implements the binary ALU ops).
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      stk_d[i] = stk_q[i];
    end
    if (push) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        stk_d[i] = stk_q[i+1];
      end
      stk_d[DEPTH-1] = din;
    end else if (pop2) begin
      for (int i = 2; i < DEPTH; i++) begin
        stk_d[i] = stk_q[i-2];
      end
      stk_d[1] = stk_q[0];
      stk_d[0] = stk_q[0];
    end else if (pop1) begin
      for (int i = 1; i < DEPTH; i++) begin
        stk_d[i] = stk_q[i-1];
      end
      stk_d[0] = stk_q[0];
    end
    if (wr_tos && !push) begin
      stk_d[DEPTH-1] = din;
    end
  end

  // Stack registers, cleared by the asynchronous reset.
  always_ff @(posedge clk_i or negedge res_ni) begin
    if (!res_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        stk_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stk_q[i] <= stk_d[i];
      end
    end
  end

  assign tos = stk_q[DEPTH-1];
  assign nos = stk_q[DEPTH-2];

endmodule
`default_nettype wire

// File: rtl/steamer_core.sv
`default_nettype none
// ============================================================================
// Module   : steamer_core
// Brief    : Parametrised Steamer stack CPU: DW-bit words holding DW/4 4-bit
//            opcodes, DEPTH-entry data stack, Wishbone-classic master with
//            byte strobes. Build option STEAMER_TRAP_EN turns unused opcodes
//            into a trap to TRAP_VECTOR (otherwise they act as NOP).
// Revision : 1.0 - initial release
// ============================================================================
module steamer_core
  import steamer_pkg::*;
#(
  parameter int            DW           = 16,
  parameter int            DEPTH        = 3,
  parameter logic [DW-1:0] RESET_VECTOR = 'hFFF0,
  parameter logic [DW-1:0] TRAP_VECTOR  = 'hFFE0
) (
  input  logic                   clk_i,
  input  logic                   res_ni,
  output logic [DW-f_bl(DW)-1:0] adr_o,
  output logic                   we_o,
  output logic                   cyc_o,
  output logic [DW/8-1:0]        stb_o,
  output logic                   vda_o,
  output logic                   vpa_o,
  output logic [DW-1:0]          dat_o,
  input  logic                   ack_i,
  input  logic [DW-1:0]          dat_i
);

  localparam int            BL      = f_bl(DW);
  localparam int            NS      = f_ns(DW);
  localparam int            NB      = DW / 8;
  localparam logic [DW-1:0] STEP    = DW'(NB);
  localparam logic [3:0]    NS_LAST = 4'(NS);
`ifdef STEAMER_TRAP_EN
  localparam bit            TRAP_EN = 1'b1;
`else
  localparam bit            TRAP_EN = 1'b0;
`endif

  phase_e        phase_q, phase_d;
  logic [3:0]    slot_q, slot_d;
  logic [DW-1:0] ir_q, ir_d;
  logic [DW-1:0] p_q, p_d;

  logic [3:0]    opc;
  logic [DW-1:0] ir_shift;
  logic          bus_cyc;
  logic          done;
  logic          go_fetch;
  logic [7:0]    rd_byte;
  logic [NB-1:0] lane_stb;

  logic          st_push, st_pop1, st_pop2, st_wr_tos;
  logic [DW-1:0] st_din;
  logic [DW-1:0] tos, nos;

  steamer_dstack #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_dstack (
    .clk_i  (clk_i),
    .res_ni (res_ni),
    .push   (st_push),
    .pop1   (st_pop1),
    .pop2   (st_pop2),
    .wr_tos (st_wr_tos),
    .din    (st_din),
    .tos    (tos),
    .nos    (nos)
  );

  assign opc      = ir_q[DW-1 -: 4];
  assign ir_shift = {ir_q[DW-5:0], 4'h0};
  assign rd_byte  = dat_i[{tos[BL-1:0], 3'b000} +: 8];
  assign lane_stb = NB'(1) << tos[BL-1:0];

  // Bus decode: every output is a pure function of phase, current opcode,
  // p and the top two stack entries. Data addresses drop z's byte bits.
  always_comb begin
    bus_cyc = 1'b0;
    we_o    = 1'b0;
    stb_o   = '0;
    vda_o   = 1'b0;
    vpa_o   = 1'b0;
    adr_o   = '0;
    dat_o   = '0;
    if (phase_q == PH_FETCH) begin
      bus_cyc = 1'b1;
      stb_o   = '1;
      vpa_o   = 1'b1;
      adr_o   = p_q[DW-1:BL];
    end else begin
      case (opc)
        OPC_LIT: begin
          bus_cyc = 1'b1;
          stb_o   = '1;
          vda_o   = 1'b1;
          vpa_o   = 1'b1;
          adr_o   = p_q[DW-1:BL];
        end
        OPC_FWM: begin
          bus_cyc = 1'b1;
          stb_o   = '1;
          vda_o   = 1'b1;
          adr_o   = tos[DW-1:BL];
        end
        OPC_SWM: begin
          bus_cyc = 1'b1;
          we_o    = 1'b1;
          stb_o   = '1;
          vda_o   = 1'b1;
          adr_o   = tos[DW-1:BL];
          dat_o   = nos;
        end
        OPC_FBM: begin
          bus_cyc = 1'b1;
          stb_o   = lane_stb;
          vda_o   = 1'b1;
          adr_o   = tos[DW-1:BL];
        end
        OPC_SBM: begin
          bus_cyc = 1'b1;
          we_o    = 1'b1;
          stb_o   = lane_stb;
          vda_o   = 1'b1;
          adr_o   = tos[DW-1:BL];
          dat_o   = {NB{nos[7:0]}};
        end
        default: begin
        end
      endcase
    end
  end

  // The cycle is withdrawn while reset is held, so a bus slave never sees
  // a request from a core that is being reset.
  assign cyc_o = bus_cyc & res_ni;
  assign done  = ~cyc_o | ack_i;

  // Sequencer: fetch, slot execution and stack control; nothing moves
  // until the current step is done, which makes wait states transparent.
  always_comb begin
    phase_d   = phase_q;
    slot_d    = slot_q;
    ir_d      = ir_q;
    p_d       = p_q;
    go_fetch  = 1'b0;
    st_push   = 1'b0;
    st_pop1   = 1'b0;
    st_pop2   = 1'b0;
    st_wr_tos = 1'b0;
    st_din    = '0;
    if (done) begin
      if (phase_q == PH_FETCH) begin
        ir_d = dat_i;
        p_d  = p_q + STEP;
        // An all-NOP word would do nothing, so it is skipped at fetch.
        if (dat_i != '0) begin
          phase_d = PH_SLOT;
          slot_d  = 4'd1;
        end
      end else begin
        ir_d     = ir_shift;
        slot_d   = slot_q + 4'd1;
        go_fetch = (ir_shift == '0) || (slot_q == NS_LAST);
        case (opc)
          OPC_LIT: begin
            st_push = 1'b1;
            st_din  = dat_i;
            p_d     = p_q + STEP;
          end
          OPC_FWM: begin
            st_wr_tos = 1'b1;
            st_din    = dat_i;
          end
          OPC_FBM: begin
            st_wr_tos = 1'b1;
            st_din    = DW'(rd_byte);
          end
          OPC_SWM, OPC_SBM: begin
            st_pop2 = 1'b1;
          end
          OPC_ADD: begin
            st_pop1   = 1'b1;
            st_wr_tos = 1'b1;
            st_din    = nos + tos;
          end
          OPC_AND: begin
            st_pop1   = 1'b1;
            st_wr_tos = 1'b1;
            st_din    = nos & tos;
          end
          OPC_XOR: begin
            st_pop1   = 1'b1;
            st_wr_tos = 1'b1;
            st_din    = nos ^ tos;
          end
          OPC_ZGO: begin
            st_pop2 = 1'b1;
            if (nos == '0) begin
              p_d      = {tos[DW-1:BL], BL'(0)};
              go_fetch = 1'b1;
            end
          end
          OPC_NOP: begin
          end
          default: begin
            // Unused opcode: p already holds the address of the next word,
            // which is what a trap handler needs to return to.
            if (TRAP_EN) begin
              st_push  = 1'b1;
              st_din   = p_q;
              p_d      = TRAP_VECTOR;
              go_fetch = 1'b1;
            end
          end
        endcase
        if (go_fetch) begin
          phase_d = PH_FETCH;
        end
      end
    end
  end

  // Architectural state registers with asynchronous reset to the boot vector.
  always_ff @(posedge clk_i or negedge res_ni) begin
    if (!res_ni) begin
      phase_q <= PH_FETCH;
      slot_q  <= 4'd1;
      ir_q    <= '0;
      p_q     <= RESET_VECTOR;
    end else begin
      phase_q <= phase_d;
      slot_q  <= slot_d;
      ir_q    <= ir_d;
      p_q     <= p_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_steamer_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_steamer_core
// Brief    : Scoreboard bench for steamer_core (DW=16, DEPTH=3). An ISA-level
//            reference model predicts every bus transaction and the number of
//            bus-idle clocks before it; a random-wait-state slave memory
//            compares each acknowledged DUT cycle against the prediction.
// Revision : 1.0 - initial release
// ============================================================================
module tb_steamer_core;
  import steamer_pkg::*;

  localparam int          DW    = 16;
  localparam int          DEPTH = 3;
  localparam logic [15:0] RV    = 16'hFFF0;
  localparam logic [15:0] TV    = 16'hFFE0;
  localparam int          NTXN  = 300;
  localparam int          NRUNS = 4;

  logic        clk_i = 1'b0;
  logic        res_ni = 1'b0;
  logic [14:0] adr_o;
  logic        we_o, cyc_o, vda_o, vpa_o;
  logic [1:0]  stb_o;
  logic [15:0] dat_o;
  logic        ack_i = 1'b0;
  logic [15:0] dat_i = '0;

  steamer_core #(
    .DW           (DW),
    .DEPTH        (DEPTH),
    .RESET_VECTOR (RV),
    .TRAP_VECTOR  (TV)
  ) dut (
    .clk_i  (clk_i),
    .res_ni (res_ni),
    .adr_o  (adr_o),
    .we_o   (we_o),
    .cyc_o  (cyc_o),
    .stb_o  (stb_o),
    .vda_o  (vda_o),
    .vpa_o  (vpa_o),
    .dat_o  (dat_o),
    .ack_i  (ack_i),
    .dat_i  (dat_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [14:0] adr;
    logic        we;
    logic [1:0]  stb;
    logic        vda;
    logic        vpa;
    logic [15:0] dat;
    int          gap;
  } txn_t;

  txn_t        exp_q[$];
  txn_t        e;
  logic [15:0] bus_mem [32768];
  logic [15:0] ref_mem [32768];
  logic [15:0] mstk[$];
  int          checks = 0;
  int          errors = 0;
  int          popped = 0;
  bit          run_en = 1'b0;
  bit          busy = 1'b0;
  int          waits = 0;
  int          gap_cnt = 0;

  // ---------------- reference model (instruction-set level) ----------------
  function automatic void m_push(input logic [15:0] v);
    mstk.push_back(v);
    void'(mstk.pop_front());
  endfunction

  function automatic logic [15:0] m_pop();
    logic [15:0] v;
    v = mstk.pop_back();
    mstk.push_front(mstk[0]);
    return v;
  endfunction

  function automatic void expect_txn(input logic [14:0] adr, input logic we,
                                     input logic [1:0] stb, input logic vda,
                                     input logic vpa, input logic [15:0] dat,
                                     input int gap);
    txn_t t;
    t.adr = adr; t.we = we; t.stb = stb; t.vda = vda; t.vpa = vpa;
    t.dat = dat; t.gap = gap;
    exp_q.push_back(t);
  endfunction

  task automatic model_run(input int n);
    logic [15:0] p, w, y, z;
    logic [3:0]  op;
    int          gap;
    p = RV;
    gap = 0;
    mstk.delete();
    for (int i = 0; i < DEPTH; i++) mstk.push_back('0);
    while (exp_q.size() < n) begin
      expect_txn(p[15:1], 1'b0, 2'b11, 1'b0, 1'b1, '0, gap);
      gap = 0;
      w = ref_mem[p[15:1]];
      p = p + 16'd2;
      for (int s = 0; s < DW / 4 && w != 16'h0; s++) begin
        op = w[15:12];
        w  = w << 4;
        z  = mstk[DEPTH-1];
        y  = mstk[DEPTH-2];
        case (op)
          OPC_LIT: begin
            expect_txn(p[15:1], 1'b0, 2'b11, 1'b1, 1'b1, '0, gap);
            gap = 0;
            m_push(ref_mem[p[15:1]]);
            p = p + 16'd2;
          end
          OPC_FWM: begin
            expect_txn(z[15:1], 1'b0, 2'b11, 1'b1, 1'b0, '0, gap);
            gap = 0;
            mstk[DEPTH-1] = ref_mem[z[15:1]];
          end
          OPC_SWM: begin
            expect_txn(z[15:1], 1'b1, 2'b11, 1'b1, 1'b0, y, gap);
            gap = 0;
            ref_mem[z[15:1]] = y;
            void'(m_pop());
            void'(m_pop());
          end
          OPC_FBM: begin
            expect_txn(z[15:1], 1'b0, z[0] ? 2'b10 : 2'b01, 1'b1, 1'b0, '0, gap);
            gap = 0;
            mstk[DEPTH-1] = z[0] ? {8'h00, ref_mem[z[15:1]][15:8]}
                                 : {8'h00, ref_mem[z[15:1]][7:0]};
          end
          OPC_SBM: begin
            expect_txn(z[15:1], 1'b1, z[0] ? 2'b10 : 2'b01, 1'b1, 1'b0,
                       {y[7:0], y[7:0]}, gap);
            gap = 0;
            if (z[0]) ref_mem[z[15:1]][15:8] = y[7:0];
            else      ref_mem[z[15:1]][7:0]  = y[7:0];
            void'(m_pop());
            void'(m_pop());
          end
          OPC_ADD: begin gap++; void'(m_pop()); mstk[DEPTH-1] = y + z; end
          OPC_AND: begin gap++; void'(m_pop()); mstk[DEPTH-1] = y & z; end
          OPC_XOR: begin gap++; void'(m_pop()); mstk[DEPTH-1] = y ^ z; end
          OPC_ZGO: begin
            gap++;
            void'(m_pop());
            void'(m_pop());
            if (y == 16'h0) begin
              p = {z[15:1], 1'b0};
              w = '0;
            end
          end
          default: begin
            gap++;
`ifdef STEAMER_TRAP_EN
            m_push(p);
            p = TV;
            w = '0;
`endif
          end
        endcase
      end
    end
  endtask

  // ---------------- memory image ----------------
  task automatic init_mem(input int run);
    logic [15:0] v;
    for (int i = 0; i < 32768; i++) begin
      case ($urandom_range(0, 3))
        0:       v = 16'h0000;
        1:       v = 16'($urandom_range(0, 7));
        default: v = 16'($urandom);
      endcase
      bus_mem[i] = v;
      ref_mem[i] = v;
    end
    if (run == 0) begin
      // Boot code: LIT 3, LIT 4, ADD; SBM/FBM on byte 0x0101; then p wraps
      // to 0 where a taken ZGO jumps to 0x0200.
      bus_mem[15'h7FF8] = 16'h1140; bus_mem[15'h7FF9] = 16'h0003;
      bus_mem[15'h7FFA] = 16'h0004; bus_mem[15'h7FFB] = 16'h11B0;
      bus_mem[15'h7FFC] = 16'h00AB; bus_mem[15'h7FFD] = 16'h0101;
      bus_mem[15'h7FFE] = 16'h1A00; bus_mem[15'h7FFF] = 16'h0101;
      bus_mem[15'h0000] = 16'h1174; bus_mem[15'h0001] = 16'h0000;
      bus_mem[15'h0002] = 16'h0200; bus_mem[15'h0080] = 16'hCD12;
      bus_mem[15'h0100] = 16'hC000;
      for (int i = 0; i < 32768; i++) ref_mem[i] = bus_mem[i];
    end
  endtask

  // ---------------- slave memory + scoreboard monitor ----------------
  // Evaluated on the falling edge: response is stable across the rising edge.
  always @(negedge clk_i) begin
    if (!res_ni || !run_en) begin
      ack_i   = 1'b0;
      dat_i   = '0;
      busy    = 1'b0;
      gap_cnt = 0;
    end else if (!cyc_o) begin
      ack_i = 1'b0;
      dat_i = 16'($urandom);
      gap_cnt++;
    end else begin
      if (!busy) begin
        busy  = 1'b1;
        waits = $urandom_range(0, 2);
      end
      if (waits == 0) begin
        ack_i = 1'b1;
        busy  = 1'b0;
        dat_i = bus_mem[adr_o];
        if (we_o && stb_o[0]) bus_mem[adr_o][7:0]  = dat_o[7:0];
        if (we_o && stb_o[1]) bus_mem[adr_o][15:8] = dat_o[15:8];
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL txn: unexpected cycle adr=%h we=%b", adr_o, we_o);
        end else begin
          e = exp_q.pop_front();
          if (adr_o !== e.adr || we_o !== e.we || stb_o !== e.stb ||
              vda_o !== e.vda || vpa_o !== e.vpa ||
              (e.we && dat_o !== e.dat) || gap_cnt != e.gap) begin
            errors++;
            $display("FAIL txn%0d: got adr=%h we=%b stb=%b vda=%b vpa=%b dat=%h gap=%0d, want adr=%h we=%b stb=%b vda=%b vpa=%b dat=%h gap=%0d",
                     popped, adr_o, we_o, stb_o, vda_o, vpa_o, dat_o, gap_cnt,
                     e.adr, e.we, e.stb, e.vda, e.vpa, e.dat, e.gap);
          end
        end
        popped++;
        gap_cnt = 0;
      end else begin
        waits--;
        ack_i = 1'b0;
        dat_i = 16'($urandom);
      end
    end
  end

  // ---------------- sequencing ----------------
  initial begin
    for (int run = 0; run < NRUNS; run++) begin
      res_ni = 1'b0;
      run_en = 1'b0;
      exp_q.delete();
      init_mem(run);
      model_run(NTXN);
      popped = 0;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      checks++;
      if (cyc_o !== 1'b0) begin
        errors++;
        $display("FAIL reset_cyc: cyc_o=%b, want 0", cyc_o);
      end
      @(posedge clk_i);
      #2;
      res_ni = 1'b1;
      run_en = 1'b1;
      #1;
      checks++;
      if (cyc_o !== 1'b1 || adr_o !== 15'h7FF8 || stb_o !== 2'b11 ||
          vpa_o !== 1'b1 || vda_o !== 1'b0 || we_o !== 1'b0) begin
        errors++;
        $display("FAIL first_fetch: cyc=%b adr=%h stb=%b vpa=%b vda=%b we=%b, want 1 7ff8 11 1 0 0",
                 cyc_o, adr_o, stb_o, vpa_o, vda_o, we_o);
      end
      for (int c = 0; c < NTXN * 30 && popped < NTXN; c++) @(posedge clk_i);
      if (popped < NTXN) begin
        checks++;
        errors++;
        $display("FAIL timeout: %0d transactions seen, want %0d", popped, NTXN);
      end
      // Asynchronous reset in the middle of activity must drop the cycle.
      #2;
      res_ni = 1'b0;
      run_en = 1'b0;
      #1;
      checks++;
      if (cyc_o !== 1'b0) begin
        errors++;
        $display("FAIL async_reset_cyc: cyc_o=%b, want 0", cyc_o);
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
